fifo_uart_tx: RTL and testbench

Drain stage that sits directly downstream of the team's synchronous FIFO and consumes its first-word-fall-through read port. It pops one DWIDTH-bit word at a time and transmits it on a single UART line as DWIDTH/8 consecutive 8N1 frames, least-significant byte first. It has a programmable bit period and back-to-back streaming. The FIFO absorbs bursts; this block paces them out at line rate.

---
 rtl/fifo_uart_tx_if.sv | 35 +++
 rtl/fifo_uart_tx.sv | 168 ++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_uart_tx_if.sv
// ----------------------------------------------------------------------------
// fifo_uart_tx_if
//
// Purpose:
//   Bundles the first-word-fall-through read port of the synchronous FIFO
//   that feeds the UART drain stage.
//
// Signals:
//   fifo_dout   [DWIDTH] FIFO head word, valid whenever fifo_empty = 0
//   fifo_empty  [1]      FIFO empty flag
//   fifo_pop    [1]      single-cycle pop strobe back to the FIFO
//
// Modports:
//   master : the FIFO side (drives head word and empty flag, receives pop)
//   slave  : the consumer side (samples head word and empty flag, drives pop)
// ----------------------------------------------------------------------------
interface fifo_uart_tx_if #(
    parameter int DWIDTH = 16
);
    logic [DWIDTH-1:0] fifo_dout;
    logic              fifo_empty;
    logic              fifo_pop;

    modport master (
        output fifo_dout,
        output fifo_empty,
        input  fifo_pop
    );

    modport slave (
        input  fifo_dout,
        input  fifo_empty,
        output fifo_pop
    );
endinterface

// File: rtl/fifo_uart_tx.sv
// ----------------------------------------------------------------------------
// fifo_uart_tx
//
// Purpose:
//   Drain stage behind the team's synchronous FIFO. Pops one DWIDTH-bit word
//   at a time and sends it on a single UART line as DWIDTH/8 consecutive 8N1
//   frames, least-significant byte first and least-significant bit first
//   within each byte. Consecutive bytes of a word follow with no gap; a
//   following word starts one idle (high) cycle after the last stop bit,
//   which the receiver sees as a slightly longer stop bit.
//
// Parameters:
//   DWIDTH        word width of the FIFO read port, multiple of 8, >= 8
//   CLKS_PER_BIT  clock cycles per UART bit, >= 2
//
// Ports:
//   clk    in   single clock, all state changes on the rising edge
//   reset  in   asynchronous, active-high reset; aborts any word in flight
//   fifo   if   FIFO read port (slave modport): fifo_dout, fifo_empty in,
//               fifo_pop out (combinational, only ever high in IDLE)
//   tx     out  registered serial line, idle high
//   busy   out  high while a word is being transmitted
// ----------------------------------------------------------------------------
module fifo_uart_tx #(
    parameter int DWIDTH       = 16,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic           clk,
    input  logic           reset,
    fifo_uart_tx_if.slave  fifo,
    output logic           tx,
    output logic           busy
);

    // ------------------------------------------------------------------
    // Derived sizes
    // ------------------------------------------------------------------
    localparam int NBYTES = DWIDTH / 8;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    // A single-byte word still needs a one-bit byte counter to stay legal.
    localparam int BYTE_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NBYTES - 1);
    localparam logic [2:0]        BIT_LAST  = 3'd7;

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]        state;
    logic [DWIDTH-1:0] shift_reg;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_cnt;
    logic [BYTE_W-1:0] byte_cnt;

    logic pop;
    logic baud_done;

    // ------------------------------------------------------------------
    // Combinational outputs
    // ------------------------------------------------------------------
    // NOTE: continuous assignments with every term on the right-hand side
    // cannot infer a latch; the reset term keeps the FIFO from losing a word
    // while this block is held in reset.
    assign pop           = (state == S_IDLE) && !fifo.fifo_empty && !reset;
    assign fifo.fifo_pop = pop;
    assign busy          = (state != S_IDLE);
    assign baud_done     = (baud_cnt == BAUD_LAST);

    // ------------------------------------------------------------------
    // Frame sequencer
    //
    // tx is loaded with the level of the *next* bit on the same edge that
    // moves into that bit, so the line is a clean flop output and changes
    // exactly on bit boundaries.
    //
    // The shift register shifts right at the end of every data bit. After
    // eight shifts the next byte of the word sits in bits [7:0], so no byte
    // selection mux is needed.
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register in this block sees the pre-edge values of the others.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            // NOTE: the shift register is reset along with the control
            // state; it is only a DWIDTH-bit datapath register, and a known
            // value keeps simulation free of X after an aborted word.
            shift_reg <= '0;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            tx        <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        // fifo_dout is sampled only here; later changes at
                        // the FIFO head do not reach the word in flight.
                        shift_reg <= fifo.fifo_dout;
                        baud_cnt  <= '0;
                        bit_cnt   <= '0;
                        byte_cnt  <= '0;
                        tx        <= 1'b0;
                        state     <= S_START;
                    end
                end

                S_START: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        tx       <= shift_reg[0];
                        state    <= S_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end

                S_DATA: begin
                    if (baud_done) begin
                        baud_cnt  <= '0;
                        shift_reg <= shift_reg >> 1;
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
                            tx      <= 1'b1;
                            state   <= S_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            // Bit 1 becomes bit 0 after this edge's shift.
                            tx      <= shift_reg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end

                S_STOP: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (byte_cnt == BYTE_LAST) begin
                            tx    <= 1'b1;
                            state <= S_IDLE;
                        end else begin
                            // Next byte of the same word starts with no gap.
                            byte_cnt <= byte_cnt + BYTE_W'(1);
                            tx       <= 1'b0;
                            state    <= S_START;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end

                default: begin
                    tx    <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// ----------------------------------------------------------------------------
// tb_fifo_uart_tx
//
// Two instances: a 16-bit word / 4 clocks-per-bit drain fed by a queue-based
// FIFO model, and an 8-bit word / 2 clocks-per-bit drain with a fixed head
// word. For the 16-bit instance every pop pushes the expected line levels
// (start, data, stop for each byte) and the expected bytes into queues; a
// per-cycle monitor pops and compares the line, busy and pop, and a separate
// UART receiver decodes the line and compares bytes.
// ----------------------------------------------------------------------------
module tb_fifo_uart_tx;

    localparam int C16 = 4;
    localparam int C8  = 2;

    logic clk = 1'b0;
    logic reset16;
    logic reset8;
    logic tx16, busy16, tx8, busy8;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fifo_uart_tx_if #(.DWIDTH(16)) f16 ();
    fifo_uart_tx_if #(.DWIDTH(8))  f8  ();

    fifo_uart_tx #(.DWIDTH(16), .CLKS_PER_BIT(C16)) dut16 (
        .clk   (clk),
        .reset (reset16),
        .fifo  (f16),
        .tx    (tx16),
        .busy  (busy16)
    );

    fifo_uart_tx #(.DWIDTH(8), .CLKS_PER_BIT(C8)) dut8 (
        .clk   (clk),
        .reset (reset8),
        .fifo  (f8),
        .tx    (tx8),
        .busy  (busy8)
    );

    // ------------------------------------------------------------------
    // Check bookkeeping
    // ------------------------------------------------------------------
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // FIFO model for the 16-bit instance
    // ------------------------------------------------------------------
    logic [15:0] fifo_q[$];
    bit          pop_pending = 1'b0;
    int          n_pushed = 0;

    // An empty FIFO shows garbage on its head, changing every cycle, so a
    // word in flight is exercised against a moving fifo_dout.
    task automatic fifo_drive16();
        if (fifo_q.size() > 0) begin
            f16.fifo_dout  = fifo_q[0];
            f16.fifo_empty = 1'b0;
        end else begin
            f16.fifo_dout  = 16'($urandom);
            f16.fifo_empty = 1'b1;
        end
    endtask

    always begin
        @(posedge clk);
        #1;
        if (pop_pending) begin
            pop_pending = 1'b0;
            if (fifo_q.size() > 0) void'(fifo_q.pop_front());
        end
        fifo_drive16();
    end

    task automatic push16(input logic [15:0] w);
        @(posedge clk);
        #1;
        fifo_q.push_back(w);
        n_pushed++;
        fifo_drive16();
    endtask

    // ------------------------------------------------------------------
    // Scoreboard queues and per-cycle monitor (16-bit instance)
    // ------------------------------------------------------------------
    logic       exp_line[$];
    logic [7:0] exp_bytes[$];
    int         pop_times[$];
    int         pops16 = 0;

    logic        m_exp_tx;
    logic        m_exp_busy;
    logic        m_exp_pop;
    logic [15:0] m_word;
    logic [7:0]  m_byte;

    always @(negedge clk) begin
        if (reset16) begin
            check("reset_tx16",   tx16,         1'b1);
            check("reset_busy16", busy16,       1'b0);
            check("reset_pop16",  f16.fifo_pop, 1'b0);
            exp_line.delete();
            exp_bytes.delete();
            pop_pending = 1'b0;
        end else begin
            m_exp_busy = (exp_line.size() > 0);
            m_exp_tx   = m_exp_busy ? exp_line.pop_front() : 1'b1;
            m_exp_pop  = !m_exp_busy && !f16.fifo_empty;
            check("tx16",   tx16,         m_exp_tx);
            check("busy16", busy16,       m_exp_busy);
            check("pop16",  f16.fifo_pop, m_exp_pop);
            if (f16.fifo_pop === 1'b1 && fifo_q.size() > 0) begin
                m_word = fifo_q[0];
                pops16++;
                pop_times.push_back(cyc);
                pop_pending = 1'b1;
                for (int b = 0; b < 2; b++) begin
                    m_byte = m_word[8*b +: 8];
                    exp_bytes.push_back(m_byte);
                    for (int k = 0; k < C16; k++) exp_line.push_back(1'b0);
                    for (int i = 0; i < 8; i++)
                        for (int k = 0; k < C16; k++) exp_line.push_back(m_byte[i]);
                    for (int k = 0; k < C16; k++) exp_line.push_back(1'b1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // UART receiver (16-bit instance): samples each bit at its centre
    // ------------------------------------------------------------------
    logic [7:0] rx_byte;
    logic       rx_stop;
    bit         rx_abort;

    always begin
        @(negedge clk);
        if (!reset16 && tx16 === 1'b0) begin
            rx_abort = 1'b0;
            rx_byte  = '0;
            rx_stop  = 1'b0;
            for (int k = 1; k <= 9*C16 + C16/2; k++) begin
                @(negedge clk);
                if (reset16) begin
                    rx_abort = 1'b1;
                    break;
                end
                if (k >= C16 + C16/2 && ((k - C16/2) % C16) == 0) begin
                    if ((k - C16/2) / C16 - 1 < 8) rx_byte[(k - C16/2) / C16 - 1] = tx16;
                    else                          rx_stop = tx16;
                end
            end
            if (!rx_abort) begin
                check("rx_stop_bit", rx_stop, 1'b1);
                check("rx_byte_expected", (exp_bytes.size() > 0), 1'b1);
                if (exp_bytes.size() > 0) check("rx_byte", rx_byte, exp_bytes.pop_front());
            end
        end
    end

    // ------------------------------------------------------------------
    // Reference line level for an 8N1 frame: index 0 start, 1..8 data, 9 stop
    // ------------------------------------------------------------------
    function automatic logic frame_level(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return b[idx-1];
    endfunction

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    int          base_pops;
    int          t;
    int          phase;
    logic [7:0]  w8;

    initial begin
        reset16 = 1'b1;
        reset8  = 1'b1;
        fifo_drive16();
        f8.fifo_dout  = 8'h00;
        f8.fifo_empty = 1'b1;

        repeat (3) @(posedge clk);
        #3;
        reset16 = 1'b0;

        // Empty FIFO after reset: the monitor checks tx=1, busy=0, pop=0.
        repeat (1000) @(posedge clk);
        check("no_pop_while_empty", pops16, 0);

        // Single word A55A.
        base_pops = pops16;
        push16(16'hA55A);
        repeat (100) @(posedge clk);
        check("single_word_pops", pops16 - base_pops, 1);
        check("single_word_bytes_left", exp_bytes.size(), 0);

        // Three words queued at once: pops 81 cycles apart.
        pop_times.delete();
        @(posedge clk);
        #1;
        fifo_q.push_back(16'h0001);
        fifo_q.push_back(16'hFFFF);
        fifo_q.push_back(16'h8000);
        n_pushed += 3;
        fifo_drive16();
        repeat (260) @(posedge clk);
        check("three_word_pops", pop_times.size(), 3);
        if (pop_times.size() == 3) begin
            check("pop_to_pop_1", pop_times[1] - pop_times[0], 81);
            check("pop_to_pop_2", pop_times[2] - pop_times[1], 81);
        end

        // Asynchronous reset at cycle 37 of a word; the aborted word is
        // not re-popped and the next head word follows in full.
        base_pops = pops16;
        @(posedge clk);
        #1;
        fifo_q.push_back(16'h1234);
        fifo_q.push_back(16'hBEEF);
        n_pushed += 2;
        fifo_drive16();
        repeat (37) @(posedge clk);
        #3;
        check("busy_before_reset", busy16, 1'b1);
        reset16 = 1'b1;
        #1;
        check("async_reset_tx",   tx16,         1'b1);
        check("async_reset_busy", busy16,       1'b0);
        check("async_reset_pop",  f16.fifo_pop, 1'b0);
        repeat (2) @(posedge clk);
        #3;
        reset16 = 1'b0;
        #1;
        check("pop_after_reset_release", f16.fifo_pop, 1'b1);
        repeat (100) @(posedge clk);
        check("reset_test_pops", pops16 - base_pops, 2);
        check("reset_test_fifo_drained", fifo_q.size(), 0);

        // Randomized traffic with random gaps, sometimes queuing up.
        for (int n = 0; n < 40; n++) begin
            push16(16'($urandom));
            repeat ($urandom_range(0, 120)) @(posedge clk);
        end
        t = 0;
        while ((fifo_q.size() > 0 || busy16 !== 1'b0) && t < 20000) begin
            @(posedge clk);
            t++;
        end
        check("drain_in_time", (t < 20000), 1'b1);
        repeat (5) @(posedge clk);
        check("all_words_popped_once", pops16, n_pushed);
        check("no_bytes_outstanding", exp_bytes.size(), 0);
        check("no_line_outstanding", exp_line.size(), 0);

        // 8-bit instance: head word C3 held non-empty for three words.
        @(negedge clk);
        check("reset_tx8",   tx8,         1'b1);
        check("reset_busy8", busy8,       1'b0);
        w8 = 8'hC3;
        f8.fifo_dout  = w8;
        f8.fifo_empty = 1'b0;
        #1;
        check("reset_pop8", f8.fifo_pop, 1'b0);
        @(posedge clk);
        #3;
        reset8 = 1'b0;
        for (int k = 0; k < 63; k++) begin
            @(negedge clk);
            phase = k % 21;
            check("pop8",  f8.fifo_pop, (phase == 0));
            check("busy8", busy8,       (phase != 0));
            check("tx8",   tx8,         (phase == 0) ? 1'b1 : frame_level(w8, (phase - 1) / C8));
            if (phase != 0) f8.fifo_dout = 8'($urandom);
            else            f8.fifo_dout = w8;
            // Keep the head word stable across the pop edge.
            if (phase == 20) f8.fifo_dout = w8;
        end
        f8.fifo_empty = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_tx8",   tx8,   1'b1);
        check("idle_busy8", busy8, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
